// File: rtl/wb_writer.sv
// rtl/wb_writer.sv - register-file write-back sequencer
// Queues ALU and load results in an in-order FIFO and drains one per cycle into the write port.
module wb_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [ADDR_W-1:0]       alu_dest,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    alu_ready,
  input  logic                    mem_valid,
  input  logic [ADDR_W-1:0]       mem_dest,
  input  logic [DATA_W-1:0]       mem_data,
  output logic                    mem_ready,
  input  logic                    hold,
  output logic                    write_en,
  output logic [ADDR_W-1:0]       write_dest,
  output logic [DATA_W-1:0]       write_val,
  input  logic [ADDR_W-1:0]       chk_a_addr,
  input  logic [ADDR_W-1:0]       chk_b_addr,
  output logic                    chk_a_pend,
  output logic                    chk_b_pend,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] destMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic              space;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pushDest;
  logic [DATA_W-1:0] pushData;

  assign pop        = (count != '0) && !hold;
  assign write_en   = pop;
  assign write_dest = pop ? destMem[rdPtr] : '0;
  assign write_val  = pop ? dataMem[rdPtr] : '0;

  // A full FIFO still has room when its head leaves this cycle.
  assign space     = (count < CNT_W'(DEPTH)) || pop;
  assign mem_ready = space;
  assign alu_ready = space && !mem_valid;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign pushDest  = mem_valid ? mem_dest : alu_dest;
  assign pushData  = mem_valid ? mem_data : alu_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      if (push)
        wrPtr <= wrPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage is intentionally left out of reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      destMem[wrPtr] <= pushDest;
      dataMem[wrPtr] <= pushData;
    end
  end

  always_comb begin
    chk_a_pend = 1'b0;
    chk_b_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (destMem[rdPtr + PTR_W'(i)] == chk_a_addr)
          chk_a_pend = 1'b1;
        if (destMem[rdPtr + PTR_W'(i)] == chk_b_addr)
          chk_b_pend = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_writer.sv
// tb/tb_wb_writer.sv - scoreboard bench for wb_writer
// Queue-level reference model predicts handshakes; a monitor checks every register-file write.
module tb_wb_writer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_dest = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              alu_ready;
  logic              mem_valid = 1'b0;
  logic [ADDR_W-1:0] mem_dest = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_ready;
  logic              hold = 1'b0;
  logic              write_en;
  logic [ADDR_W-1:0] write_dest;
  logic [DATA_W-1:0] write_val;
  logic [ADDR_W-1:0] chk_a_addr = '0;
  logic [ADDR_W-1:0] chk_b_addr = '0;
  logic              chk_a_pend;
  logic              chk_b_pend;
  logic [$clog2(DEPTH):0] count;

  wb_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .hold(hold), .write_en(write_en), .write_dest(write_dest), .write_val(write_val),
    .chk_a_addr(chk_a_addr), .chk_b_addr(chk_b_addr),
    .chk_a_pend(chk_a_pend), .chk_b_pend(chk_b_pend), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t modelQ[$];
  ent_t sbQ[$];
  ent_t aluPend[$];
  ent_t memPend[$];
  int   passCnt = 0;
  int   totalCnt = 0;

  function automatic ent_t mk(int d, int v);
    ent_t e;
    e.dest = ADDR_W'(d);
    e.data = DATA_W'(v);
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    totalCnt++;
    if (act === exp)
      passCnt++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive, compare against the model at negedge, advance the model at posedge.
  task automatic step(input bit doRst = 1'b0);
    bit   mv, av, expWe, sp, pa, pb;
    int   n;
    ent_t e;
    rst = doRst;
    mv = !doRst && (memPend.size() > 0);
    av = !doRst && (aluPend.size() > 0);
    mem_valid = mv;
    alu_valid = av;
    if (mv) begin
      mem_dest = memPend[0].dest;
      mem_data = memPend[0].data;
    end
    if (av) begin
      alu_dest = aluPend[0].dest;
      alu_data = aluPend[0].data;
    end
    @(negedge clk);
    n = modelQ.size();
    expWe = (n > 0) && !hold;
    sp = (n < DEPTH) || expWe;
    pa = 1'b0;
    pb = 1'b0;
    foreach (modelQ[i]) begin
      if (modelQ[i].dest == chk_a_addr) pa = 1'b1;
      if (modelQ[i].dest == chk_b_addr) pb = 1'b1;
    end
    check("write_en", write_en, expWe);
    check("count", count, n);
    check("mem_ready", mem_ready, sp);
    check("alu_ready", alu_ready, sp && !mv);
    check("chk_a_pend", chk_a_pend, pa);
    check("chk_b_pend", chk_b_pend, pb);
    if (!expWe)
      check("idle_port", {write_dest, write_val}, '0);
    @(posedge clk);
    if (doRst) begin
      modelQ.delete();
      sbQ.delete();
    end else begin
      if (expWe)
        void'(modelQ.pop_front());
      if (mv && sp) begin
        e = memPend.pop_front();
        modelQ.push_back(e);
        sbQ.push_back(e);
      end else if (av && sp) begin
        e = aluPend.pop_front();
        modelQ.push_back(e);
        sbQ.push_back(e);
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (modelQ.size() > 0 || aluPend.size() > 0 || memPend.size() > 0); k++)
      step();
    check("drain_done", modelQ.size() + aluPend.size() + memPend.size(), 0);
  endtask

  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      if (write_en) begin
        if (sbQ.size() == 0) begin
          totalCnt++;
          $display("FAIL unexpected_write: dest %0d val %0h with nothing queued at %0t",
                   write_dest, write_val, $time);
        end else begin
          e = sbQ.pop_front();
          check("write_dest", write_dest, e.dest);
          check("write_val", write_val, e.data);
        end
      end
    end
  end

  initial begin : stimulus
    step(1'b1);
    step(1'b1);
    step();

    aluPend.push_back(mk(3, 16'h1234));
    repeat (3) step();

    memPend.push_back(mk(5, 16'hAAAA));
    aluPend.push_back(mk(6, 16'h5555));
    repeat (4) step();

    hold = 1'b1;
    for (int d = 1; d <= 5; d++)
      aluPend.push_back(mk(d, 16'h1000 + d));
    repeat (5) step();
    hold = 1'b0;
    drain();

    hold = 1'b1;
    for (int d = 8; d <= 11; d++)
      aluPend.push_back(mk(d, 16'h2000 + d));
    repeat (4) step();
    hold = 1'b0;
    memPend.push_back(mk(12, 16'hBEEF));
    step();
    drain();

    hold = 1'b1;
    chk_a_addr = 4'd7;
    chk_b_addr = 4'd2;
    aluPend.push_back(mk(7, 16'h7777));
    repeat (2) step();
    hold = 1'b0;
    drain();
    step();

    hold = 1'b1;
    for (int d = 13; d <= 15; d++)
      aluPend.push_back(mk(d, 16'h3000 + d));
    repeat (3) step();
    step(1'b1);
    hold = 1'b0;
    repeat (3) step();

    for (int it = 0; it < 400; it++) begin
      hold = ($urandom_range(0, 9) < 3);
      if (aluPend.size() == 0 && $urandom_range(0, 1) == 1)
        aluPend.push_back(mk($urandom_range(0, 15), $urandom_range(0, 16'hFFFF)));
      if (memPend.size() == 0 && $urandom_range(0, 2) == 0)
        memPend.push_back(mk($urandom_range(0, 15), $urandom_range(0, 16'hFFFF)));
      chk_a_addr = ADDR_W'($urandom_range(0, 15));
      chk_b_addr = ADDR_W'($urandom_range(0, 15));
      step();
    end
    hold = 1'b0;
    drain();
    step();
    check("scoreboard_empty", sbQ.size(), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-back sequencer that drives the register file's single write port (write enable, destination index, write value) from two result producers: the ALU path and the memory-load path.
- Buffers results in a small in-order FIFO so that both producers can complete in the same cycle, and so the write port can be frozen by a hold input.
- Exposes pending-write lookups so decode can detect read-after-write hazards against queued results.

Parameters:
- DATA_W, 16, width of the register value.
- ADDR_W, 4, width of the register index; the register file holds 2**ADDR_W entries.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result valid.
- alu_dest  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when high together with alu_valid.
- mem_valid  in  1  load result valid.
- mem_dest  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load result.
- mem_ready  out  1  load result accepted this cycle when high together with mem_valid.
- hold  in  1  freezes draining of the FIFO into the register file.
- write_en  out  1  register-file write enable.
- write_dest  out  ADDR_W  register-file write index.
- write_val  out  DATA_W  register-file write data.
- chk_a_addr, chk_b_addr  in  ADDR_W  source registers to test for pending writes.
- chk_a_pend, chk_b_pend  out  1  a queued write targets chk_x_addr.
- count  out  $clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Storage: circular FIFO with rd_ptr, wr_ptr and count.
  - Reset (sync, rst high at the edge): rd_ptr=0, wr_ptr=0, count=0. All queued entries are discarded and never written.
  - Entry data is not cleared by reset.
- Drain (combinational):
  - write_en = (count>0) && !hold.
  - When write_en=1: write_dest and write_val are the head entry.
  - When write_en=0: write_dest=0 and write_val=0.
- Pop: on a rising edge with write_en=1, rd_ptr advances by 1, wrapping modulo DEPTH. The register file samples write_* on its own write edge within that cycle.
- Space: space = (count<DEPTH) || write_en. A full FIFO may accept an entry in the same cycle it pops one.
- Arbitration (at most one enqueue per cycle; load path has priority):
  - mem_ready = space.
  - alu_ready = space && !mem_valid.
  - Enqueue when (mem_valid && mem_ready) or (alu_valid && alu_ready). The selected {dest,data} is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Producers hold valid, dest and data stable until accepted; valid is never withdrawn before acceptance.
- Count update per edge: count += push - pop. A simultaneous push and pop leaves count unchanged.
- Latency: an entry accepted at edge E with the FIFO empty and hold low has write_en high in the cycle after E. Minimum latency is 1 cycle; throughput is 1 write per cycle.
- Ordering: writes leave in acceptance order. Two queued entries with the same dest are both written, and the later one wins.
- Pending lookup (combinational): chk_x_pend=1 if any occupied entry, including the head, has dest==chk_x_addr. Slots outside [rd_ptr, rd_ptr+count) are ignored.
- Hold: with hold high, the FIFO still accepts entries until full, then both readies drop. When hold falls, draining resumes in that same cycle.
- Reset mid-operation: ready outputs go low only if space is false. After reset, count=0, so both readies are high in the first cycle after reset.

Test Plan:
- Single write: reset, then alu_valid=1, dest=3, data=0x1234 for one cycle -> next cycle write_en=1, write_dest=3, write_val=0x1234; following cycle write_en=0, count=0.
- Collision: mem (dest 5, 0xAAAA) and alu (dest 6, 0x5555) both valid in cycle 0 -> mem accepted and alu_ready=0 in cycle 0; alu accepted in cycle 1; writes appear as r5=0xAAAA, then r6=0x5555 on consecutive cycles.
- Fill under hold: hold=1, push 5 ALU results (dest 1..5) -> first 4 accepted, count=4, alu_ready=0 for the 5th. Release hold -> writes r1..r4 in order, and the 5th is accepted in the first released cycle and written last.
- Full simultaneous push/pop: count=4, hold=0, mem_valid=1 -> mem_ready=1, count stays 4, wr_ptr wraps to 0 with no data loss.
- Hazard lookup: queue dest 7 under hold, chk_a_addr=7, chk_b_addr=2 -> chk_a_pend=1, chk_b_pend=0. After drain, chk_a_pend=0.
- Reset mid-operation: 3 entries queued under hold, assert rst for one cycle, then drop hold -> write_en never asserts, count=0, both readies=1.
